round_sequencer: RTL and testbench
==================================

Name: round_sequencer

Overview:
- Game-loop controller that sits downstream of the pattern generator and the input trimmer, and upstream of the 7-segment score display.
- Starts a game when the level is chosen and requests each new pattern.
- Waits for the player's trimmed input, compares it with the pattern under the level mask, and counts rounds and correct answers.
- Pulses a loop reset to the pattern, print and trim stages between rounds, and latches the final score after NUM_ROUNDS rounds.

Parameters:
- NUM_ROUNDS, 10, rounds per game (1..15).
- CLR_CYCLES, 4, cycles loop_rst is held high between rounds (>=1).
- GAP_CYCLES, 500, idle cycles after loop_rst before the next gen_req (0.5 s at 1 kHz; 0 allowed).
- SCORE_PER_WIN, 10, points per correct round.

Ports:
- clk  in  1  1 kHz game clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-select done; level signal, rising edge used.
- level  in  3  one-hot level: 001 = 8 slots, 010 = 12 slots, 100 = 16 slots.
- pattern_flat  in  48  16 slots x 3 bits; slot k is bits [3k+2:3k].
- trimmed_flat  in  48  player input in the same slot layout.
- gen_done  in  1  pattern generator finished; level, rising edge used.
- trim_done  in  1  input trimmer finished; level, rising edge used.
- gen_req  out  1  one-cycle pulse requesting a new pattern.
- loop_rst  out  1  active-high clear for the per-round stages.
- round_count  out  5  rounds completed.
- answer_count  out  4  rounds won.
- last_win  out  1  result of the most recent round.
- score  out  7  final score; 0 until DONE.
- game_end  out  1  high in DONE.
- busy  out  1  high in any state except IDLE and DONE.

Behaviour:
- Reset values: every output 0, state IDLE, mask 0, edge-detect registers 0.
- Edge detection: start, gen_done and trim_done are registered; rise = current & ~previous.
- An edge that occurs in a state that does not consume it is discarded, not queued.
- IDLE:
  - On start rise with a valid one-hot level: latch slot mask (001 -> 0x00FF, 010 -> 0x0FFF, 100 -> 0xFFFF), clear both counts, go to GEN.
  - On start rise with an invalid level (000 or multi-hot): stay in IDLE, no outputs change.
- GEN:
  - gen_req is high only in the first cycle of GEN.
  - On gen_done rise, go to PLAY. A gen_done rise in the same cycle as gen_req is accepted.
- PLAY: on trim_done rise, go to LATCH.
- LATCH (1 cycle):
  - win = AND over k of (~mask[k] | pattern[k] == trimmed[k]). Masked-off slots are ignored.
  - Register round_count+1, answer_count+win and last_win=win.
  - Counts become visible 2 cycles after the trim_done edge.
  - Next state: DONE if the new round_count equals NUM_ROUNDS, otherwise CLEAR.
- CLEAR: loop_rst is high for exactly CLR_CYCLES cycles, then go to GAP.
- GAP:
  - Count GAP_CYCLES cycles, then go to GEN.
  - With GAP_CYCLES = 0, go from CLEAR straight to GEN.
- DONE:
  - On entry, score = answer_count * SCORE_PER_WIN, computed at full width and saturated to 127.
  - game_end is held high; loop_rst is not asserted on the final round.
  - All inputs are ignored; only rst leaves DONE.
- Level changes after start have no effect, because the mask is latched in IDLE.
- rst asserted mid-game: immediate return to IDLE with all outputs 0, including a gen_req or loop_rst in progress.
- Counter widths: round_count must not exceed NUM_ROUNDS; answer_count <= round_count <= 15.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, GEN, PLAY, LATCH, CLEAR, GAP, DONE;
  - level one-hot codes LV1 = 001, LV2 = 010, LV3 = 100;
  - slot masks and slot width 3.
- One sub-module: pattern_compare, combinational. Inputs are mask, pattern_flat and trimmed_flat; output is win. Reusable in other checks.
- Edge detectors and timers stay inline.

Test Plan:
- Reset, then start rise with level 001, pattern equal to trimmed -> gen_req 1 cycle later; after gen_done and trim_done, answer_count=1, round_count=1, last_win=1, loop_rst high 4 cycles.
- Level 001, patterns differ only in slot 10 -> win=1. Same mismatch with level 100 -> win=0, answer_count unchanged.
- Ten rounds with 7 wins -> game_end=1, score=70, no loop_rst after round 10; a further start rise is ignored.
- Start rise with level 000, then 011 -> stays IDLE, gen_req never pulses, busy=0.
- rst during CLEAR (loop_rst=1) -> loop_rst, counts and busy are 0 in the same cycle; the next valid start begins from round 0.
- trim_done held high through LATCH, or rising during GEN or GAP -> no extra round counted; gen_done rising in PLAY is ignored.

Source files
------------

// File: rtl/round_sequencer_pkg.sv
// Shared definitions for the round sequencer: state codes, level codes, slot layout and masks.
// Also holds the slot-mask decode and the saturating score helper.
package round_sequencer_pkg;

   localparam int SLOT_W    = 3;
   localparam int NUM_SLOTS = 16;
   localparam int FLAT_W    = SLOT_W * NUM_SLOTS;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GEN   = 3'd1,
      S_PLAY  = 3'd2,
      S_LATCH = 3'd3,
      S_CLEAR = 3'd4,
      S_GAP   = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [2:0] LV1 = 3'b001;
   localparam logic [2:0] LV2 = 3'b010;
   localparam logic [2:0] LV3 = 3'b100;

   localparam logic [NUM_SLOTS-1:0] MASK_LV1 = 16'h00FF;
   localparam logic [NUM_SLOTS-1:0] MASK_LV2 = 16'h0FFF;
   localparam logic [NUM_SLOTS-1:0] MASK_LV3 = 16'hFFFF;

   function automatic logic [NUM_SLOTS-1:0] level_mask(input logic [2:0] lv);
      logic [NUM_SLOTS-1:0] m;
      case (lv)
         LV1:     m = MASK_LV1;
         LV2:     m = MASK_LV2;
         LV3:     m = MASK_LV3;
         default: m = '0;
      endcase
      return m;
   endfunction

   // Product is formed at full int width so large SCORE_PER_WIN values clamp instead of wrapping.
   function automatic logic [6:0] sat_score(input logic [3:0] wins, input int per);
      int prod;
      prod = int'(wins) * per;
      return (prod > 127) ? 7'd127 : prod[6:0];
   endfunction

endpackage

// File: rtl/pattern_compare.sv
// Combinational slot-wise compare of player input against the pattern; slots with mask bit 0 are ignored.
// win_o is 1 only when every enabled slot matches.
module pattern_compare
   import round_sequencer_pkg::*;
(
   input  logic [NUM_SLOTS-1:0] mask_i,
   input  logic [FLAT_W-1:0]    pattern_flat_i,
   input  logic [FLAT_W-1:0]    trimmed_flat_i,
   output logic                 win_o
);

   always_comb begin
      win_o = 1'b1;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (mask_i[k] &&
             (pattern_flat_i[k*SLOT_W +: SLOT_W] != trimmed_flat_i[k*SLOT_W +: SLOT_W]))
            win_o = 1'b0;
      end
   end

endmodule

// File: rtl/round_sequencer.sv
// Game-loop controller: requests patterns, scores trimmed player input, pulses loop_rst between rounds.
// Round results appear two cycles after the trim_done edge; edges arriving in a non-consuming state are dropped.
module round_sequencer
   import round_sequencer_pkg::*;
#(
   parameter int NUM_ROUNDS    = 10,
   parameter int CLR_CYCLES    = 4,
   parameter int GAP_CYCLES    = 500,
   parameter int SCORE_PER_WIN = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [2:0]    level,
   input  logic [47:0]   pattern_flat,
   input  logic [47:0]   trimmed_flat,
   input  logic          gen_done,
   input  logic          trim_done,
   output logic          gen_req,
   output logic          loop_rst,
   output logic [4:0]    round_count,
   output logic [3:0]    answer_count,
   output logic          last_win,
   output logic [6:0]    score,
   output logic          game_end,
   output logic          busy
);

   localparam int TIMER_W = 16;

   state_t                state_q, state_d;
   logic [NUM_SLOTS-1:0]  mask_q, mask_d;
   logic [TIMER_W-1:0]    timer_q, timer_d;
   logic [4:0]            rounds_q, rounds_d;
   logic [3:0]            wins_q, wins_d;
   logic                  last_win_q, last_win_d;
   logic [6:0]            score_q, score_d;
   logic                  gen_req_q, gen_req_d;
   logic                  start_q, gen_done_q, trim_done_q;

   logic start_rise, gen_rise, trim_rise, level_ok, win;

   assign start_rise = start & ~start_q;
   assign gen_rise   = gen_done & ~gen_done_q;
   assign trim_rise  = trim_done & ~trim_done_q;
   assign level_ok   = (level == LV1) || (level == LV2) || (level == LV3);

   pattern_compare u_compare (
      .mask_i         (mask_q),
      .pattern_flat_i (pattern_flat),
      .trimmed_flat_i (trimmed_flat),
      .win_o          (win)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         timer_q     <= '0;
         rounds_q    <= '0;
         wins_q      <= '0;
         last_win_q  <= 1'b0;
         score_q     <= '0;
         gen_req_q   <= 1'b0;
         start_q     <= 1'b0;
         gen_done_q  <= 1'b0;
         trim_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         timer_q     <= timer_d;
         rounds_q    <= rounds_d;
         wins_q      <= wins_d;
         last_win_q  <= last_win_d;
         score_q     <= score_d;
         gen_req_q   <= gen_req_d;
         start_q     <= start;
         gen_done_q  <= gen_done;
         trim_done_q <= trim_done;
      end
   end

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      timer_d    = timer_q;
      rounds_d   = rounds_q;
      wins_d     = wins_q;
      last_win_d = last_win_q;
      score_d    = score_q;
      case (state_q)
         S_IDLE: begin
            if (start_rise && level_ok) begin
               mask_d   = level_mask(level);
               rounds_d = '0;
               wins_d   = '0;
               state_d  = S_GEN;
            end
         end
         S_GEN: begin
            if (gen_rise)
               state_d = S_PLAY;
         end
         S_PLAY: begin
            if (trim_rise)
               state_d = S_LATCH;
         end
         S_LATCH: begin
            rounds_d   = rounds_q + 5'd1;
            wins_d     = wins_q + {3'b000, win};
            last_win_d = win;
            timer_d    = '0;
            if (rounds_d == 5'(NUM_ROUNDS)) begin
               score_d = sat_score(wins_d, SCORE_PER_WIN);
               state_d = S_DONE;
            end else begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (timer_q == TIMER_W'(CLR_CYCLES - 1)) begin
               timer_d = '0;
               state_d = (GAP_CYCLES == 0) ? S_GEN : S_GAP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_GAP: begin
            if (timer_q == TIMER_W'(GAP_CYCLES - 1)) begin
               timer_d = '0;
               state_d = S_GEN;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered so the pulse covers exactly the first GEN cycle, however GEN was entered.
   assign gen_req_d = (state_d == S_GEN) && (state_q != S_GEN);

   always_comb begin
      gen_req      = gen_req_q;
      loop_rst     = (state_q == S_CLEAR);
      round_count  = rounds_q;
      answer_count = wins_q;
      last_win     = last_win_q;
      score        = score_q;
      game_end     = (state_q == S_DONE);
      busy         = (state_q != S_IDLE) && (state_q != S_DONE);
   end

endmodule

// File: tb/tb_round_sequencer.sv
// Randomized bench for round_sequencer against a slot-count based round/score model.
module tb_round_sequencer;

   localparam int NUM_ROUNDS    = 10;
   localparam int CLR_CYCLES    = 4;
   localparam int GAP_CYCLES    = 500;
   localparam int SCORE_PER_WIN = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  level;
   logic [47:0] pattern_flat;
   logic [47:0] trimmed_flat;
   logic        gen_done;
   logic        trim_done;
   logic        gen_req;
   logic        loop_rst;
   logic [4:0]  round_count;
   logic [3:0]  answer_count;
   logic        last_win;
   logic [6:0]  score;
   logic        game_end;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [2:0] m_level;
   int         m_rounds;
   int         m_wins;

   always #5 clk = ~clk;

   round_sequencer #(
      .NUM_ROUNDS    (NUM_ROUNDS),
      .CLR_CYCLES    (CLR_CYCLES),
      .GAP_CYCLES    (GAP_CYCLES),
      .SCORE_PER_WIN (SCORE_PER_WIN)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .level        (level),
      .pattern_flat (pattern_flat),
      .trimmed_flat (trimmed_flat),
      .gen_done     (gen_done),
      .trim_done    (trim_done),
      .gen_req      (gen_req),
      .loop_rst     (loop_rst),
      .round_count  (round_count),
      .answer_count (answer_count),
      .last_win     (last_win),
      .score        (score),
      .game_end     (game_end),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int slots_of(input logic [2:0] lv);
      return (lv == 3'b001) ? 8 : (lv == 3'b010) ? 12 : 16;
   endfunction

   function automatic bit model_win(input logic [2:0] lv, input logic [47:0] p, input logic [47:0] t);
      for (int i = 0; i < slots_of(lv); i++)
         if (p[3*i +: 3] != t[3*i +: 3]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int exp_score(input int wins);
      int s;
      s = wins * SCORE_PER_WIN;
      return (s > 127) ? 127 : s;
   endfunction

   function automatic logic [47:0] rand_pat();
      return 48'({$urandom(), $urandom()});
   endfunction

   // Win: only slots beyond the level's range are disturbed. Loss: one active slot is altered.
   function automatic logic [47:0] make_trim(input logic [47:0] p, input logic [2:0] lv, input bit want_win);
      logic [47:0] t;
      int n, s;
      t = p;
      n = slots_of(lv);
      if (want_win) begin
         for (int i = n; i < 16; i++) t[3*i +: 3] = 3'($urandom());
      end else begin
         s = $urandom_range(0, n - 1);
         t[3*s +: 3] = p[3*s +: 3] ^ 3'($urandom_range(1, 7));
      end
      return t;
   endfunction

   task automatic start_game(input logic [2:0] lv);
      level = lv;
      start = 1'b1;
      tick();
      chk("start_gen_req", gen_req, 1);
      chk("start_busy", busy, 1);
      chk("start_rounds", round_count, 0);
      chk("start_wins", answer_count, 0);
      start    = 1'b0;
      m_level  = lv;
      m_rounds = 0;
      m_wins   = 0;
   endtask

   // Entered in the first GEN cycle; returns in the next first GEN cycle, in DONE, or after a reset in CLEAR.
   task automatic play_round(input logic [47:0] p, input logic [47:0] t, input bit extras, input bit abort_in_clear);
      int n;
      bit w, hold;
      pattern_flat = p;
      trimmed_flat = t;
      n = $urandom_range(0, 3);
      repeat (n) begin
         tick();
         chk("gen_req_single", gen_req, 0);
      end
      gen_done = 1'b1;
      tick();
      chk("play_gen_req", gen_req, 0);
      gen_done = 1'b0;
      if (extras) begin
         tick();
         gen_done = 1'b1;
         tick();
         gen_done = 1'b0;
      end
      repeat ($urandom_range(0, 3)) tick();
      chk("play_rounds", round_count, m_rounds);
      trim_done = 1'b1;
      tick();
      chk("latch_busy", busy, 1);
      chk("latch_rounds_old", round_count, m_rounds);
      w = model_win(m_level, p, t);
      m_rounds++;
      m_wins += int'(w);
      hold = 1'($urandom_range(0, 1));
      if (!hold) trim_done = 1'b0;
      tick();
      trim_done = 1'b0;
      chk("round_count", round_count, m_rounds);
      chk("answer_count", answer_count, m_wins);
      chk("last_win", last_win, w);
      if (abort_in_clear) begin
         chk("abort_loop_rst_before", loop_rst, 1);
         rst = 1'b1;
         #1;
         chk("abort_loop_rst", loop_rst, 0);
         chk("abort_rounds", round_count, 0);
         chk("abort_wins", answer_count, 0);
         chk("abort_busy", busy, 0);
         rst = 1'b0;
         tick();
         return;
      end
      if (m_rounds == NUM_ROUNDS) begin
         chk("done_game_end", game_end, 1);
         chk("done_score", score, exp_score(m_wins));
         chk("done_busy", busy, 0);
         repeat (5) begin
            chk("done_no_loop_rst", loop_rst, 0);
            tick();
         end
      end else begin
         chk("score_zero_midgame", score, 0);
         n = 0;
         while (loop_rst && n < 100) begin
            n++;
            tick();
         end
         chk("clear_len", n, CLR_CYCLES);
         n = 0;
         while (!gen_req && n < 2000) begin
            if (extras && n == 10) trim_done = 1'b1;
            if (extras && n == 12) trim_done = 1'b0;
            n++;
            tick();
         end
         chk("gap_len", n, GAP_CYCLES);
         chk("gap_no_round", round_count, m_rounds);
      end
   endtask

   initial begin
      logic [2:0]  bad_lv [2];
      bit          plan [10];
      logic [47:0] p, t;
      bit          tmp;
      int          j;

      rst = 1'b1; start = 1'b0; level = 3'b000;
      pattern_flat = '0; trimmed_flat = '0; gen_done = 1'b0; trim_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gen_req", gen_req, 0);
      chk("rst_loop_rst", loop_rst, 0);
      chk("rst_rounds", round_count, 0);
      chk("rst_wins", answer_count, 0);
      chk("rst_last_win", last_win, 0);
      chk("rst_score", score, 0);
      chk("rst_game_end", game_end, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      tick();

      bad_lv[0] = 3'b000;
      bad_lv[1] = 3'b011;
      foreach (bad_lv[i]) begin
         level = bad_lv[i];
         start = 1'b1;
         tick();
         chk("bad_level_busy", busy, 0);
         chk("bad_level_gen_req", gen_req, 0);
         start = 1'b0;
         repeat (3) begin
            tick();
            chk("bad_level_idle", gen_req, 0);
         end
      end

      // Game 1: level 001, seven wins; level is changed right after start to prove the mask is latched.
      for (int i = 0; i < 10; i++) plan[i] = (i < 7);
      for (int i = 2; i < 10; i++) begin
         j = $urandom_range(2, 9);
         tmp = plan[i]; plan[i] = plan[j]; plan[j] = tmp;
      end
      start_game(3'b001);
      level = 3'b100;
      p = rand_pat();
      play_round(p, p, 1'b0, 1'b0);
      p = rand_pat();
      t = p;
      t[32:30] = p[32:30] ^ 3'b101;
      play_round(p, t, 1'b1, 1'b0);
      for (int i = 2; i < 10; i++) begin
         p = rand_pat();
         play_round(p, make_trim(p, 3'b001, plan[i]), 1'(i % 2), 1'b0);
      end
      chk("game1_score70", score, 70);
      start = 1'b1;
      tick();
      chk("done_ignore_start_req", gen_req, 0);
      chk("done_ignore_start_end", game_end, 1);
      chk("done_ignore_start_rounds", round_count, NUM_ROUNDS);
      start = 1'b0;
      tick();

      // Game 2: level 100 with the slot-10 mismatch loses, then reset lands in CLEAR.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("reset_done_end", game_end, 0);
      chk("reset_done_score", score, 0);
      tick();
      start_game(3'b100);
      p = rand_pat();
      t = p;
      t[32:30] = p[32:30] ^ 3'b011;
      play_round(p, t, 1'b0, 1'b1);

      // Game 3: level 010, random outcomes from a fresh start.
      start_game(3'b010);
      for (int i = 0; i < NUM_ROUNDS; i++) begin
         p = rand_pat();
         play_round(p, make_trim(p, 3'b010, 1'($urandom_range(0, 1))), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog observed timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
